segment_capture_ctrl: RTL and testbench

SEGMENT_CAPTURE_CTRL -- requirements
Module: segment_capture_ctrl

---
 rtl/segment_capture_ctrl.sv | 146 ++++++++++++++
 tb/tb_segment_capture_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_capture_ctrl.sv
// Segmented ADC capture controller.
// Arms on arm_i, then writes one segment of samples to a downstream FIFO per
// capture_go_i pulse until the configured number of segments is done. A FIFO
// full or a drop of arm_i stops the capture; counters and sticky flags are kept
// for readback until the next arm.
module segment_capture_ctrl #(
    parameter int ADC_W  = 12,
    parameter int SAMP_W = 20,
    parameter int SEG_W  = 16
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              arm_i,
    input  logic              capture_go_i,
    input  logic [ADC_W-1:0]  adc_data_i,
    input  logic [SAMP_W-1:0] samples_i,
    input  logic [SEG_W-1:0]  segments_i,
    input  logic              fifo_full_i,
    output logic              fifo_wr_en_o,
    output logic [ADC_W-1:0]  fifo_data_o,
    output logic              capture_done_o,
    output logic [SEG_W-1:0]  seg_count_o,
    output logic              go_missed_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GO,
        CAPTURE,
        DONE
    } state_t;

    state_t            state_q;
    logic [SAMP_W-1:0] samp_cnt_q;
    logic [SAMP_W-1:0] samp_cfg_q;
    logic [SEG_W-1:0]  seg_cnt_q;
    logic [SEG_W-1:0]  seg_cfg_q;
    logic [ADC_W-1:0]  data_q;
    logic              done_q;
    logic              missed_q;
    logic              overflow_q;

    logic              last_samp;
    logic              last_seg;

    // Counters never exceed cfg-1, so comparing against cfg-1 cannot wrap.
    assign last_samp = (samp_cnt_q == samp_cfg_q - SAMP_W'(1));
    assign last_seg  = (seg_cnt_q == seg_cfg_q - SEG_W'(1));

    // Sample pipeline: FIFO data is the ADC sample delayed by one cycle.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= adc_data_i;
        end
    end

    // Capture sequencing, segment/sample counting and sticky status flags.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            samp_cfg_q <= '0;
            seg_cnt_q  <= '0;
            seg_cfg_q  <= '0;
            done_q     <= 1'b0;
            missed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_q    <= WAIT_GO;
                        samp_cnt_q <= '0;
                        seg_cnt_q  <= '0;
                        missed_q   <= 1'b0;
                        overflow_q <= 1'b0;
                        samp_cfg_q <= (samples_i == '0) ? SAMP_W'(1) : samples_i;
                        seg_cfg_q  <= (segments_i == '0) ? SEG_W'(1) : segments_i;
                    end
                end

                WAIT_GO: begin
                    if (!arm_i) begin
                        state_q <= IDLE;
                    end else if (capture_go_i) begin
                        state_q    <= CAPTURE;
                        samp_cnt_q <= '0;
                    end
                end

                CAPTURE: begin
                    if (!arm_i) begin
                        state_q <= IDLE;
                    end else begin
                        // A go is only usable on the final write of a segment.
                        if (capture_go_i && !last_samp) begin
                            missed_q <= 1'b1;
                        end
                        if (fifo_full_i) begin
                            overflow_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else if (last_samp) begin
                            seg_cnt_q  <= seg_cnt_q + SEG_W'(1);
                            samp_cnt_q <= '0;
                            if (last_seg) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else if (!capture_go_i) begin
                                state_q <= WAIT_GO;
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + SAMP_W'(1);
                        end
                    end
                end

                DONE: begin
                    if (capture_go_i) begin
                        missed_q <= 1'b1;
                    end
                    if (!arm_i) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO full gates the write strobe in the same cycle it is seen.
    assign fifo_wr_en_o   = (state_q == CAPTURE) && !fifo_full_i;
    assign fifo_data_o    = data_q;
    assign capture_done_o = done_q;
    assign seg_count_o    = seg_cnt_q;
    assign go_missed_o    = missed_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_segment_capture_ctrl.sv
// Self-checking bench for segment_capture_ctrl. Each cycle's outputs are logged
// on the falling edge; expected write bursts are built from the go-pulse
// schedule (writes at g+1..g+S for each accepted go at cycle g).
module tb_segment_capture_ctrl;

    localparam int ADC_W  = 12;
    localparam int SAMP_W = 20;
    localparam int SEG_W  = 16;
    localparam int MAXC   = 4096;

    logic              adc_clk;
    logic              reset;
    logic              arm_i;
    logic              capture_go_i;
    logic [ADC_W-1:0]  adc_data_i;
    logic [SAMP_W-1:0] samples_i;
    logic [SEG_W-1:0]  segments_i;
    logic              fifo_full_i;
    logic              fifo_wr_en_o;
    logic [ADC_W-1:0]  fifo_data_o;
    logic              capture_done_o;
    logic [SEG_W-1:0]  seg_count_o;
    logic              go_missed_o;
    logic              overflow_o;

    segment_capture_ctrl #(
        .ADC_W  (ADC_W),
        .SAMP_W (SAMP_W),
        .SEG_W  (SEG_W)
    ) dut (
        .adc_clk        (adc_clk),
        .reset          (reset),
        .arm_i          (arm_i),
        .capture_go_i   (capture_go_i),
        .adc_data_i     (adc_data_i),
        .samples_i      (samples_i),
        .segments_i     (segments_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_data_o    (fifo_data_o),
        .capture_done_o (capture_done_o),
        .seg_count_o    (seg_count_o),
        .go_missed_o    (go_missed_o),
        .overflow_o     (overflow_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int go_sched[$];
    int full_at  = -1;
    int abort_at = -1;
    int reset_at = -1;

    logic             wr_log   [MAXC];
    logic [ADC_W-1:0] data_log [MAXC];
    logic [ADC_W-1:0] adc_log  [MAXC];
    logic             done_log [MAXC];
    logic             miss_log [MAXC];
    logic             ovf_log  [MAXC];
    logic [SEG_W-1:0] seg_log  [MAXC];
    bit               exp_wr   [MAXC];

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    // Output log, one entry per cycle, sampled mid-cycle.
    always @(negedge adc_clk) begin
        if (cyc < MAXC) begin
            wr_log[cyc]   = fifo_wr_en_o;
            data_log[cyc] = fifo_data_o;
            adc_log[cyc]  = adc_data_i;
            done_log[cyc] = capture_done_o;
            miss_log[cyc] = go_missed_o;
            ovf_log[cyc]  = overflow_o;
            seg_log[cyc]  = seg_count_o;
        end
    end

    // Advance one cycle and apply the scheduled stimulus for the new cycle.
    task automatic step();
        @(posedge adc_clk);
        #1;
        cyc++;
        adc_data_i   = ADC_W'($urandom);
        capture_go_i = 1'b0;
        foreach (go_sched[i]) if (go_sched[i] == cyc) capture_go_i = 1'b1;
        fifo_full_i  = (cyc == full_at);
        if (cyc == abort_at) arm_i = 1'b0;
        if (cyc == reset_at) reset = 1'b1;
    endtask

    task automatic disarm();
        arm_i = 1'b0;
        go_sched.delete();
        full_at  = -1;
        abort_at = -1;
        reset_at = -1;
        step();
        step();
    endtask

    task automatic model_clear();
        foreach (exp_wr[i]) exp_wr[i] = 1'b0;
    endtask

    task automatic model_burst(input int g, input int s);
        for (int c = g + 1; c <= g + s; c++) exp_wr[c] = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge adc_clk);
        #1;
        checks++;
        if ({fifo_wr_en_o, capture_done_o, go_missed_o, overflow_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000",
                     {fifo_wr_en_o, capture_done_o, go_missed_o, overflow_o});
        end
        checks++;
        if (seg_count_o !== '0) begin
            errors++;
            $display("FAIL reset_seg: got %0d required 0", seg_count_o);
        end
        checks++;
        if (fifo_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0h required 0", fifo_data_o);
        end
    endtask

    task automatic test_single_segment();
        int a, g;
        samples_i = 8; segments_i = 1; arm_i = 1'b1;
        step();
        a = cyc;
        g = a + 1 + int'($urandom % 3);
        go_sched.push_back(g);
        while (cyc < g + 12) step();
        model_clear();
        model_burst(g, 8);
        for (int c = a; c <= g + 11; c++) begin
            checks++;
            if (wr_log[c] !== exp_wr[c]) begin
                errors++;
                $display("FAIL single_wr: cycle %0d got %b required %b", c - g, wr_log[c], exp_wr[c]);
            end
            checks++;
            if (data_log[c] !== adc_log[c-1]) begin
                errors++;
                $display("FAIL single_data: cycle %0d got %0h required %0h", c - g, data_log[c], adc_log[c-1]);
            end
        end
        checks++;
        if (done_log[g+8] !== 1'b0 || done_log[g+9] !== 1'b1) begin
            errors++;
            $display("FAIL single_done: N+8 %b N+9 %b required 0 1", done_log[g+8], done_log[g+9]);
        end
        checks++;
        if (seg_log[g+8] !== SEG_W'(0) || seg_log[g+9] !== SEG_W'(1)) begin
            errors++;
            $display("FAIL single_seg: N+8 %0d N+9 %0d required 0 1", seg_log[g+8], seg_log[g+9]);
        end
        disarm();
    endtask

    task automatic test_back_to_back();
        int g;
        samples_i = 4; segments_i = 3; arm_i = 1'b1;
        step();
        g = cyc + 1 + int'($urandom % 3);
        go_sched = '{g, g + 4, g + 8};
        while (cyc < g + 17) step();
        for (int c = g - 1; c <= g + 16; c++) begin
            checks++;
            if (wr_log[c] !== ((c >= g + 1) && (c <= g + 12))) begin
                errors++;
                $display("FAIL b2b_wr: cycle %0d got %b", c - g, wr_log[c]);
            end
        end
        checks++;
        if (done_log[g+12] !== 1'b0 || done_log[g+13] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: N+12 %b N+13 %b required 0 1", done_log[g+12], done_log[g+13]);
        end
        checks++;
        if (seg_log[g+5] !== SEG_W'(1) || seg_log[g+13] !== SEG_W'(3)) begin
            errors++;
            $display("FAIL b2b_seg: N+5 %0d N+13 %0d required 1 3", seg_log[g+5], seg_log[g+13]);
        end
        checks++;
        if (miss_log[g+16] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_missed: got %b required 0", miss_log[g+16]);
        end
        disarm();
    endtask

    task automatic test_early_go();
        int g;
        samples_i = 10; segments_i = 2; arm_i = 1'b1;
        step();
        g = cyc + 1;
        go_sched = '{g, g + 3, g + 13};
        while (cyc < g + 27) step();
        model_clear();
        model_burst(g, 10);
        model_burst(g + 13, 10);
        for (int c = g; c <= g + 26; c++) begin
            checks++;
            if (wr_log[c] !== exp_wr[c]) begin
                errors++;
                $display("FAIL early_wr: cycle %0d got %b required %b", c - g, wr_log[c], exp_wr[c]);
            end
        end
        checks++;
        if (miss_log[g+3] !== 1'b0 || miss_log[g+4] !== 1'b1) begin
            errors++;
            $display("FAIL early_missed: N+3 %b N+4 %b required 0 1", miss_log[g+3], miss_log[g+4]);
        end
        checks++;
        if (seg_log[g+11] !== SEG_W'(1) || done_log[g+24] !== 1'b1 || done_log[g+23] !== 1'b0) begin
            errors++;
            $display("FAIL early_end: seg %0d done %b%b required 1 01", seg_log[g+11], done_log[g+23], done_log[g+24]);
        end
        disarm();
    endtask

    task automatic test_fifo_full();
        int g;
        samples_i = 16; segments_i = 1; arm_i = 1'b1;
        step();
        g = cyc + 1 + int'($urandom % 2);
        go_sched.push_back(g);
        full_at = g + 5;
        while (cyc < g + 10) step();
        for (int c = g; c <= g + 9; c++) begin
            checks++;
            if (wr_log[c] !== ((c >= g + 1) && (c <= g + 4))) begin
                errors++;
                $display("FAIL full_wr: cycle %0d got %b", c - g, wr_log[c]);
            end
        end
        checks++;
        if (ovf_log[g+5] !== 1'b0 || ovf_log[g+6] !== 1'b1) begin
            errors++;
            $display("FAIL full_overflow: N+5 %b N+6 %b required 0 1", ovf_log[g+5], ovf_log[g+6]);
        end
        checks++;
        if (done_log[g+5] !== 1'b0 || done_log[g+6] !== 1'b1) begin
            errors++;
            $display("FAIL full_done: N+5 %b N+6 %b required 0 1", done_log[g+5], done_log[g+6]);
        end
        disarm();
    endtask

    task automatic test_abort();
        int g, e;
        samples_i = 4; segments_i = 4; arm_i = 1'b1;
        step();
        g = cyc + 1;
        go_sched = '{g, g + 6};
        abort_at = g + 8;
        while (cyc < g + 12) step();
        model_clear();
        model_burst(g, 4);
        model_burst(g + 6, 2);
        for (int c = g; c <= g + 11; c++) begin
            checks++;
            if (wr_log[c] !== exp_wr[c]) begin
                errors++;
                $display("FAIL abort_wr: cycle %0d got %b required %b", c - g, wr_log[c], exp_wr[c]);
            end
        end
        checks++;
        if (done_log[g+9] !== 1'b0 || seg_log[g+9] !== SEG_W'(1)) begin
            errors++;
            $display("FAIL abort_hold: done %b seg %0d required 0 1", done_log[g+9], seg_log[g+9]);
        end
        abort_at = -1;
        e = cyc;
        arm_i = 1'b1;
        step();
        step();
        checks++;
        if (seg_log[e] !== SEG_W'(1) || seg_log[e+1] !== SEG_W'(0)) begin
            errors++;
            $display("FAIL abort_rearm: before %0d after %0d required 1 0", seg_log[e], seg_log[e+1]);
        end
        disarm();
    endtask

    task automatic test_zero_config();
        int g;
        samples_i = 0; segments_i = 0; arm_i = 1'b1;
        step();
        g = cyc + 1;
        go_sched.push_back(g);
        while (cyc < g + 6) step();
        for (int c = g; c <= g + 5; c++) begin
            checks++;
            if (wr_log[c] !== (c == g + 1)) begin
                errors++;
                $display("FAIL zero_wr: cycle %0d got %b", c - g, wr_log[c]);
            end
        end
        checks++;
        if (done_log[g+2] !== 1'b1 || seg_log[g+2] !== SEG_W'(1)) begin
            errors++;
            $display("FAIL zero_done: done %b seg %0d required 1 1", done_log[g+2], seg_log[g+2]);
        end
        disarm();

        samples_i = 20; segments_i = 1; arm_i = 1'b1;
        step();
        g = cyc + 1;
        go_sched = '{g, g + 2};
        reset_at = g + 5;
        while (cyc < g + 7) step();
        checks++;
        if (wr_log[g+5] !== 1'b1 || miss_log[g+5] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: wr %b missed %b required 1 1", wr_log[g+5], miss_log[g+5]);
        end
        checks++;
        if ({wr_log[g+6], done_log[g+6], miss_log[g+6], ovf_log[g+6]} !== 4'b0 ||
            seg_log[g+6] !== '0 || data_log[g+6] !== '0) begin
            errors++;
            $display("FAIL rst_mid: wr %b done %b miss %b ovf %b seg %0d data %0h required all 0",
                     wr_log[g+6], done_log[g+6], miss_log[g+6], ovf_log[g+6], seg_log[g+6], data_log[g+6]);
        end
        reset = 1'b0;
        disarm();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int s, k, a, g, last_g;
            bit early;
            s = 1 + int'($urandom % 6);
            k = 1 + int'($urandom % 4);
            early = 1'b0;
            samples_i = SAMP_W'(s); segments_i = SEG_W'(k); arm_i = 1'b1;
            step();
            // Configuration is latched at arm; later changes must not matter.
            samples_i  = SAMP_W'($urandom);
            segments_i = SEG_W'($urandom);
            a = cyc;
            model_clear();
            g = a + 1 + int'($urandom % 3);
            for (int seg = 0; seg < k; seg++) begin
                go_sched.push_back(g);
                model_burst(g, s);
                if (s >= 3 && ($urandom % 3) == 0) begin
                    go_sched.push_back(g + 1 + int'($urandom % (s - 1)));
                    early = 1'b1;
                end
                last_g = g;
                g = ($urandom % 2) ? g + s : g + s + 1 + int'($urandom % 3);
            end
            while (cyc < last_g + s + 4) step();
            for (int c = a; c <= last_g + s + 3; c++) begin
                checks++;
                if (wr_log[c] !== exp_wr[c]) begin
                    errors++;
                    $display("FAIL rand_wr: iter %0d cycle %0d got %b required %b", it, c - a, wr_log[c], exp_wr[c]);
                end
                if (exp_wr[c]) begin
                    checks++;
                    if (data_log[c] !== adc_log[c-1]) begin
                        errors++;
                        $display("FAIL rand_data: iter %0d got %0h required %0h", it, data_log[c], adc_log[c-1]);
                    end
                end
            end
            checks++;
            if (done_log[last_g+s] !== 1'b0 || done_log[last_g+s+1] !== 1'b1) begin
                errors++;
                $display("FAIL rand_done: iter %0d got %b%b required 01", it, done_log[last_g+s], done_log[last_g+s+1]);
            end
            checks++;
            if (seg_log[last_g+s+3] !== SEG_W'(k) || miss_log[last_g+s+3] !== early) begin
                errors++;
                $display("FAIL rand_status: iter %0d seg %0d missed %b required %0d %b",
                         it, seg_log[last_g+s+3], miss_log[last_g+s+3], k, early);
            end
            disarm();
        end
    endtask

    initial begin
        reset        = 1'b1;
        arm_i        = 1'b0;
        capture_go_i = 1'b0;
        adc_data_i   = '0;
        samples_i    = '0;
        segments_i   = '0;
        fifo_full_i  = 1'b0;
        repeat (3) step();
        test_reset();
        reset = 1'b0;
        step();
        test_single_segment();
        test_back_to_back();
        test_early_go();
        test_fifo_full();
        test_abort();
        test_zero_config();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
